serial_rx: RTL and testbench
============================

# serial_rx

Serial-to-parallel frame receiver placed directly downstream of the D flip-flop stage. It consumes the DFF's registered output Q as a serial line and recovers framed bytes: idle-high line, one low start bit, WIDTH data bits LSB first, and one high stop bit, each CPB clocks long. Each good frame yields one parallel word with a one-cycle VALID strobe. A bad stop bit yields a one-cycle FERR strobe instead. SIN is already registered upstream, so the block adds no input synchronizer.

## Interface
- CPB, 4: clocks per bit; legal values are even and ≥4.
- WIDTH, 8: data bits per frame; legal values are 1..16.
- CK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- SIN  input  1  serial line from the upstream DFF Q; idles at 1.
- DOUT  output  WIDTH  last good received word; holds until the next good frame.
- VALID  output  1  one-cycle strobe; DOUT is new in that same cycle.
- FERR  output  1  one-cycle strobe on a framing error (stop bit read as 0).
- BUSY  output  1  high while a frame is being received (START, DATA, STOP).

## Operation
- One clock (CK); reset is asynchronous and active-high (RST).
- State machine states:
  - WAITHI is the reset state. It moves to IDLE on the first edge that samples SIN=1, so a line held low at reset release is never taken as a start bit.
  - IDLE moves to START on the edge that samples SIN=0 (call that edge t0). The bit counter cnt clears and the bit index clears.
  - START: cnt increments each edge. At edge t0+CPB/2 SIN is sampled as the start-bit check.
    - SIN=0: go to DATA with cnt=0.
    - SIN=1: treat as a glitch and return to IDLE. No strobe.
  - DATA: the bit i sample (i=0..WIDTH-1) is taken at edge t0+CPB/2+(i+1)·CPB.
    - Each sample shifts into a shift register, LSB first; the first received bit ends in bit 0.
    - After bit WIDTH-1, go to STOP.
  - STOP: the stop sample is taken at edge ts = t0+CPB/2+(WIDTH+1)·CPB.
    - SIN=1: DOUT gets the shift register, VALID=1 for one cycle, go to IDLE.
    - SIN=0: DOUT is unchanged, FERR=1 for one cycle, go to WAITHI. This covers a break condition: a new frame needs the line to return high first.
- cnt width is clog2(CPB). cnt wraps to 0 at each sample point and never saturates.
- The shift register is internal. DOUT only changes on a good frame.
- BUSY=1 exactly in START, DATA and STOP.

## Timing
- Reset values: DOUT=0, VALID=0, FERR=0, BUSY=0, state=WAITHI, cnt=0. All take effect immediately on RST assertion, without waiting for a CK edge.
- Reset mid-frame aborts the frame silently: no VALID, no FERR, and DOUT keeps its reset value 0.
- Latency:
  - VALID and FERR are registered outputs, high during the cycle after edge ts. That is CPB/2+(WIDTH+1)·CPB+1 cycles after the start edge t0.
  - With the defaults this is 39 cycles.
- Back-to-back frames are supported: a start bit sampled on edge ts+1 is accepted. There is no dead cycle beyond the return to IDLE at ts.
- VALID and FERR are never high in the same cycle, and each is never high for two consecutive cycles.
- SIN changes between sample points are ignored. Only the mid-bit samples matter, which tolerates ±(CPB/2-1) clocks of bit-edge skew.

## Test plan
- Reset release with SIN=0 held for 10 cycles, then SIN=1 for 2 cycles -> no BUSY while low; state reaches IDLE; DOUT=0, VALID=0.
- Defaults (CPB=4, WIDTH=8), frame 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles) -> DOUT=8'hA5, with VALID high for exactly the one cycle 39 cycles after the start edge; BUSY high from t0+1 through ts.
- Two frames back-to-back, 0x3C then 0xFF, with no idle gap -> two VALID pulses 40 cycles apart; DOUT=3C, then FF.
- Start glitch: SIN low for 1 cycle, then high -> returns to IDLE; no VALID, no FERR; DOUT unchanged.
- Frame 0x55 with the stop bit driven 0 -> FERR one cycle at t0+39; DOUT keeps its previous value. A following valid frame is ignored until SIN has returned to 1, then decodes correctly.
- RST pulsed mid-DATA of frame 0x81 -> all outputs 0 immediately, no strobe; the next full frame 0x81 decodes to DOUT=8'h81.

Source files
------------

// File: rtl/serial_rx.sv
// serial_rx: serial-to-parallel frame receiver.
//
// Recovers framed words from an idle-high serial line. A frame is one low
// start bit, WIDTH data bits (LSB first) and one high stop bit. Each bit is
// CPB clocks long, and every bit is sampled at its midpoint. SIN is already
// registered upstream, so this block has no input synchronizer.
//
// Parameters:
//   CPB    clocks per bit (even, >= 4)
//   WIDTH  data bits per frame (1..16)
// Ports:
//   CK     clock; all state changes on the rising edge
//   RST    asynchronous, active-high reset
//   SIN    serial line input, idles at 1
//   DOUT   last good received word; holds until the next good frame
//   VALID  one-cycle strobe; DOUT is new in the same cycle
//   FERR   one-cycle strobe when the stop bit is read as 0
//   BUSY   high while a frame is in progress (START, DATA, STOP)
module serial_rx #(
   parameter int CPB   = 4,
   parameter int WIDTH = 8
) (
   input  logic             CK,
   input  logic             RST,
   input  logic             SIN,
   output logic [WIDTH-1:0] DOUT,
   output logic             VALID,
   output logic             FERR,
   output logic             BUSY
);

   localparam int CW = $clog2(CPB);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);  // start-bit midpoint
   localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);      // one full bit later
   localparam logic [IW-1:0] IDX_LAST  = IW'(WIDTH - 1);

   typedef enum logic [2:0] {WAITHI, IDLE, START, DATA, STOP} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] shreg;

   // NOTE: every register here, the shift register included, is reset so that
   // an aborted frame leaves no trace and DOUT reads 0 straight out of reset.
   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         state <= WAITHI;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
         DOUT  <= '0;
         VALID <= 1'b0;
         FERR  <= 1'b0;
         BUSY  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout; the strobes default low
         // here and are raised below for a single cycle.
         VALID <= 1'b0;
         FERR  <= 1'b0;
         case (state)
            // Wait for the line to be high before arming, so a line held low
            // (at reset release or after a break) never looks like a start bit.
            WAITHI: begin
               if (SIN) state <= IDLE;
            end
            IDLE: begin
               if (!SIN) begin
                  state <= START;
                  cnt   <= '0;
                  idx   <= '0;
                  BUSY  <= 1'b1;
               end
            end
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  if (SIN) begin
                     // The line is back high at mid start bit: treat it as a glitch.
                     state <= IDLE;
                     BUSY  <= 1'b0;
                  end else begin
                     state <= DATA;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt <= '0;
                  // Shift right with new bits entering at the top, so the first
                  // bit received ends up in bit 0.
                  shreg <= (shreg >> 1) | (WIDTH'(SIN) << (WIDTH - 1));
                  if (idx == IDX_LAST) state <= STOP;
                  else                 idx   <= idx + IW'(1);
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt  <= '0;
                  BUSY <= 1'b0;
                  if (SIN) begin
                     DOUT  <= shreg;
                     VALID <= 1'b1;
                     state <= IDLE;
                  end else begin
                     FERR  <= 1'b1;
                     state <= WAITHI;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= WAITHI;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: self-checking bench for serial_rx (CPB=4, WIDTH=8).
//
// The frame driver pushes the expected strobe (kind, DOUT, and the cycle it
// is due) onto a scoreboard queue. A monitor pops and compares an entry each
// time VALID or FERR rises. A stimulus table covers the regular frames.
// Hand-written sequences cover reset, the BUSY window, back-to-back frames,
// a start glitch, a framing error with a break, and reset in mid-frame.
module tb_serial_rx;

   localparam int CPB   = 4;
   localparam int WIDTH = 8;
   // Number of edges from the start edge t0 to the stop sample edge ts.
   localparam int TS_OFS = CPB / 2 + (WIDTH + 1) * CPB;

   logic             CK;
   logic             RST;
   logic             SIN;
   logic [WIDTH-1:0] DOUT;
   logic             VALID;
   logic             FERR;
   logic             BUSY;

   serial_rx #(.CPB(CPB), .WIDTH(WIDTH)) dut (
      .CK    (CK),
      .RST   (RST),
      .SIN   (SIN),
      .DOUT  (DOUT),
      .VALID (VALID),
      .FERR  (FERR),
      .BUSY  (BUSY)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge CK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic             ferr;
      logic [WIDTH-1:0] dout;
      int               due;   // cycle whose edge (ts) launches the strobe
   } exp_t;

   exp_t sb[$];

   // Monitor: sampled on the falling edge, away from the active edge.
   logic prev_strobe = 1'b0;
   always @(negedge CK) begin
      exp_t e;
      if (VALID || FERR) begin
         check("strobe_exclusive", 32'(VALID & FERR), 32'd0);
         check("strobe_one_cycle", 32'(prev_strobe), 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_strobe", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            check("strobe_kind_ferr", 32'(FERR), 32'(e.ferr));
            check("strobe_dout", 32'(DOUT), 32'(e.dout));
            check("strobe_cycle", 32'(cyc), 32'(e.due));
         end
      end
      prev_strobe <= VALID | FERR;
   end

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   task automatic idle(input int n);
      SIN = 1'b1;
      repeat (n) tick();
   endtask

   // Drive one full frame; report the cycles (relative to t0) in which BUSY was seen high.
   task automatic send_frame(input logic [WIDTH-1:0] data, input logic stop,
                             input logic exp_ferr, input logic [WIDTH-1:0] exp_dout,
                             output int busy_cnt, output int first_k, output int last_k);
      logic [WIDTH+1:0] line;
      exp_t e;
      int t0;
      line     = {stop, data, 1'b0};
      t0       = cyc + 1;
      e.ferr   = exp_ferr;
      e.dout   = exp_dout;
      e.due    = t0 + TS_OFS;
      sb.push_back(e);
      busy_cnt = 0;
      first_k  = -1;
      last_k   = -1;
      for (int b = 0; b < WIDTH + 2; b++) begin
         SIN = line[b];
         for (int c = 0; c < CPB; c++) begin
            tick();
            if (BUSY) begin
               busy_cnt++;
               if (first_k < 0) first_k = cyc - t0;
               last_k = cyc - t0;
            end
         end
      end
   endtask

   typedef struct {
      logic [WIDTH-1:0] data;
      logic             stop;
      logic             exp_ferr;
      logic [WIDTH-1:0] exp_dout;
   } vec_t;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs[6];
      int bc, fk, lk;
      logic [2:0] bits;

      vecs[0] = '{8'h00, 1'b1, 1'b0, 8'h00};
      vecs[1] = '{8'hFF, 1'b1, 1'b0, 8'hFF};
      vecs[2] = '{8'h01, 1'b1, 1'b0, 8'h01};
      vecs[3] = '{8'h80, 1'b1, 1'b0, 8'h80};
      vecs[4] = '{8'h55, 1'b0, 1'b1, 8'h80};  // bad stop: DOUT holds 80
      vecs[5] = '{8'hC3, 1'b1, 1'b0, 8'hC3};

      // Reset, with the line held low through and after reset release.
      RST = 1'b1;
      SIN = 1'b0;
      repeat (3) tick();
      check("reset_dout", 32'(DOUT), 32'd0);
      check("reset_valid", 32'(VALID), 32'd0);
      check("reset_ferr", 32'(FERR), 32'd0);
      check("reset_busy", 32'(BUSY), 32'd0);
      RST = 1'b0;
      bc = 0;
      repeat (10) begin
         tick();
         if (BUSY) bc++;
      end
      check("busy_while_low", 32'(bc), 32'd0);
      idle(2);
      check("armed_dout", 32'(DOUT), 32'd0);
      check("armed_valid", 32'(VALID), 32'd0);
      check("armed_busy", 32'(BUSY), 32'd0);

      // Frame 0xA5 out of reset, with the BUSY window measured relative to t0.
      send_frame(8'hA5, 1'b1, 1'b0, 8'hA5, bc, fk, lk);
      check("a5_busy_count", 32'(bc), 32'(TS_OFS));
      check("a5_busy_first", 32'(fk), 32'd0);
      check("a5_busy_last", 32'(lk), 32'(TS_OFS - 1));
      idle(4);
      check("a5_dout_hold", 32'(DOUT), 32'hA5);

      // Table of regular frames.
      for (int i = 0; i < 6; i++) begin
         send_frame(vecs[i].data, vecs[i].stop, vecs[i].exp_ferr, vecs[i].exp_dout, bc, fk, lk);
         idle(4);
      end

      // Back-to-back frames with no idle gap: the strobes come 40 cycles apart.
      send_frame(8'h3C, 1'b1, 1'b0, 8'h3C, bc, fk, lk);
      send_frame(8'hFF, 1'b1, 1'b0, 8'hFF, bc, fk, lk);
      idle(4);
      check("b2b_dout", 32'(DOUT), 32'hFF);

      // Start glitch: a single low cycle must be rejected.
      SIN = 1'b0;
      tick();
      idle(6);
      check("glitch_busy", 32'(BUSY), 32'd0);
      check("glitch_dout", 32'(DOUT), 32'hFF);

      // Framing error followed by a break: the line stays low, and nothing
      // starts until it goes high again.
      send_frame(8'h55, 1'b0, 1'b1, 8'hFF, bc, fk, lk);
      SIN = 1'b0;
      bc = 0;
      repeat (8) begin
         tick();
         if (BUSY) bc++;
      end
      check("break_busy", 32'(bc), 32'd0);
      idle(2);
      send_frame(8'h5A, 1'b1, 1'b0, 8'h5A, bc, fk, lk);
      idle(4);

      // Reset in mid-DATA of frame 0x81: the start bit, then data bits 1,0,0.
      bits = 3'b001;
      SIN = 1'b0;
      repeat (CPB) tick();
      for (int b = 0; b < 3; b++) begin
         SIN = bits[b];
         repeat (CPB) tick();
      end
      check("midframe_busy", 32'(BUSY), 32'd1);
      #2 RST = 1'b1;
      #1;
      check("async_rst_dout", 32'(DOUT), 32'd0);
      check("async_rst_busy", 32'(BUSY), 32'd0);
      check("async_rst_valid", 32'(VALID), 32'd0);
      check("async_rst_ferr", 32'(FERR), 32'd0);
      SIN = 1'b1;
      tick();
      RST = 1'b0;
      idle(3);
      check("abort_dout", 32'(DOUT), 32'd0);
      send_frame(8'h81, 1'b1, 1'b0, 8'h81, bc, fk, lk);
      idle(4);
      check("after_abort_dout", 32'(DOUT), 32'h81);

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
